// File: rtl/float12_pkg.sv
// Shared definitions for the 12-bit float format used by the adder datapath
// and its converters: sign[11], exponent[10:6] (bias 15), mantissa[5:0].
package float12_pkg;

    localparam int SGN_BIT  = 11;
    localparam int EXP_MSB  = 10;
    localparam int EXP_LSB  = 6;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
    localparam int MAN_W    = 6;
    localparam int EXP_BIAS = 15;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float12_t;

    // A zero exponent encodes zero, whatever the sign and mantissa hold.
    function automatic logic f12_is_zero(input float12_t f);
        return (f.exp == '0);
    endfunction

endpackage

// File: rtl/f12_round_shift.sv
// Combinational magnitude alignment: shifts the 7-bit significand by
// e - 21 + FRAC_W, rounding half-up when bits fall off the bottom.
module f12_round_shift
    import float12_pkg::*;
#(
    parameter int FRAC_W = 8,
    parameter int MAG_W  = 17 + FRAC_W
) (
    input  logic [EXP_W-1:0] exp_val,
    input  logic [MAN_W:0]   m7,
    input  logic             zero,
    output logic [MAG_W-1:0] mag
);

    // Biased exponent minus (bias + mantissa width) plus output fraction bits.
    localparam logic signed [7:0] SH_OFS = 8'(FRAC_W - EXP_BIAS - MAN_W);

    logic signed [7:0] sh;
    logic [2:0]        r;
    logic [7:0]        rnd;

    always_comb begin
        sh  = $signed({3'b000, exp_val}) + SH_OFS;
        r   = 3'(-sh);
        rnd = '0;
        mag = '0;
        if (zero) begin
            mag = '0;
        end else if (!sh[7]) begin
            mag = MAG_W'(m7) << sh[5:0];
        end else if (sh >= -8'sd7) begin
            rnd = ({1'b0, m7} + (8'd1 << (r - 3'd1))) >> r;
            mag = MAG_W'(rnd);
        end else begin
            mag = '0;
        end
    end

endmodule

// File: rtl/float12_to_fixed.sv
// Three-stage float12 -> signed fixed-point converter with valid/ready
// handshaking, optional negative clipping and saturation flag.
module float12_to_fixed
    import float12_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [11:0]      in_data_i,
    input  logic             neg_clip_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             sat_o
);

    localparam int          MAG_W   = 17 + FRAC_W;
    localparam logic [63:0] POS_MAX = (64'd1 << (OUT_W - 1)) - 64'd1;
    localparam logic [63:0] NEG_MAG = 64'd1 << (OUT_W - 1);

    float12_t in_word;
    logic     adv;

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [MAN_W:0]   s1_m7_reg;
    logic             s1_zero_reg;
    logic             s1_clip_reg;

    logic             s2_valid_reg;
    logic             s2_sign_reg;
    logic             s2_clip_reg;
    logic [MAG_W-1:0] s2_mag_reg;

    logic             s3_valid_reg;
    logic [OUT_W-1:0] s3_data_reg;
    logic             s3_sat_reg;

    logic [MAG_W-1:0] mag_next;
    logic [63:0]      mag_wide;
    logic [OUT_W-1:0] s3_data_next;
    logic             s3_sat_next;

    assign in_word     = in_data_i;
    assign adv         = ~s3_valid_reg | out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = s3_valid_reg;
    assign out_data_o  = s3_data_reg;
    assign sat_o       = s3_sat_reg;

    f12_round_shift #(
        .FRAC_W (FRAC_W),
        .MAG_W  (MAG_W)
    ) u_round_shift (
        .exp_val (s1_exp_reg),
        .m7      (s1_m7_reg),
        .zero    (s1_zero_reg),
        .mag     (mag_next)
    );

    // Clipping wins over saturation; a zero magnitude is never negated.
    always_comb begin
        mag_wide     = 64'(s2_mag_reg);
        s3_data_next = '0;
        s3_sat_next  = 1'b0;
        if (s2_sign_reg && s2_clip_reg) begin
            s3_data_next = '0;
            s3_sat_next  = 1'b0;
        end else if (!s2_sign_reg || (mag_wide == 64'd0)) begin
            if (mag_wide > POS_MAX) begin
                s3_data_next = OUT_W'(POS_MAX);
                s3_sat_next  = 1'b1;
            end else begin
                s3_data_next = OUT_W'(mag_wide);
            end
        end else begin
            if (mag_wide > NEG_MAG) begin
                s3_data_next = OUT_W'(NEG_MAG);
                s3_sat_next  = 1'b1;
            end else begin
                s3_data_next = OUT_W'(-mag_wide);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_m7_reg    <= '0;
            s1_zero_reg  <= 1'b0;
            s1_clip_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_clip_reg  <= 1'b0;
            s2_mag_reg   <= '0;
            s3_valid_reg <= 1'b0;
            s3_data_reg  <= '0;
            s3_sat_reg   <= 1'b0;
        end else if (adv) begin
            // Whole pipe moves as one; empty slots travel as bubbles.
            s1_valid_reg <= in_valid_i;
            s1_sign_reg  <= in_word.sign;
            s1_exp_reg   <= in_word.exp;
            s1_m7_reg    <= {1'b1, in_word.man};
            s1_zero_reg  <= f12_is_zero(in_word);
            s1_clip_reg  <= neg_clip_i;

            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            s2_clip_reg  <= s1_clip_reg;
            s2_mag_reg   <= mag_next;

            s3_valid_reg <= s2_valid_reg;
            s3_data_reg  <= s3_data_next;
            s3_sat_reg   <= s3_sat_next;
        end
    end

endmodule

// File: tb/tb_float12_to_fixed.sv
// Directed-vector bench for float12_to_fixed (OUT_W=16, FRAC_W=8).
module tb_float12_to_fixed;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        neg_clip = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        sat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] d;
        logic        clip;
        logic [15:0] q;
        logic        s;
    } vec_t;

    vec_t vecs[18];

    float12_to_fixed #(.OUT_W(16), .FRAC_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .neg_clip_i  (neg_clip),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .sat_o       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Single word through an idle pipe: checks latency, data and flag.
    task automatic run_vec(input logic [11:0] d, input logic c,
                           input logic [15:0] q, input logic s);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        neg_clip = c;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        $display("vec in=0x%03h clip=%0d -> out=0x%04h sat=%0d lat=%0d", d, c, out_data, sat, lat);
        check("latency", 32'(lat), 32'd3);
        check("data", 32'(out_data), 32'(q));
        check("sat", 32'(sat), 32'(s));
        neg_clip = 1'b0;
    endtask

    logic [11:0] bp_in[4];
    logic [15:0] bp_exp[4];

    initial begin
        int idx_in;
        int got;
        int stall_cnt;
        int extra;
        bit stalled_once;

        vecs[0]  = '{12'h3C0, 1'b0, 16'h0100, 1'b0};
        vecs[1]  = '{12'hC10, 1'b0, 16'hFD80, 1'b0};
        vecs[2]  = '{12'h3E0, 1'b0, 16'h0180, 1'b0};
        vecs[3]  = '{12'h180, 1'b0, 16'h0001, 1'b0};
        vecs[4]  = '{12'h140, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{12'h03F, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{12'h800, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{12'h7FF, 1'b0, 16'h7FFF, 1'b1};
        vecs[8]  = '{12'hFFF, 1'b0, 16'h8000, 1'b1};
        vecs[9]  = '{12'h580, 1'b0, 16'h7FFF, 1'b1};
        vecs[10] = '{12'hD80, 1'b0, 16'h8000, 1'b0};
        vecs[11] = '{12'hC10, 1'b1, 16'h0000, 1'b0};
        vecs[12] = '{12'hFFF, 1'b1, 16'h0000, 1'b0};
        vecs[13] = '{12'h3C0, 1'b1, 16'h0100, 1'b0};
        vecs[14] = '{12'h400, 1'b0, 16'h0200, 1'b0};
        vecs[15] = '{12'h1C0, 1'b0, 16'h0001, 1'b0};
        vecs[16] = '{12'h1FF, 1'b0, 16'h0002, 1'b0};
        vecs[17] = '{12'h9C0, 1'b0, 16'hFFFF, 1'b0};

        bp_in  = '{12'h3C0, 12'h400, 12'h440, 12'h480};
        bp_exp = '{16'h0100, 16'h0200, 16'h0400, 16'h0800};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: out_valid=%0d out_data=0x%04h sat=%0d in_ready=%0d", out_valid, out_data, sat, in_ready);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i].d, vecs[i].clip, vecs[i].q, vecs[i].s);

        // Backpressure: stall 2 cycles when the first result appears.
        repeat (2) @(negedge clk);
        idx_in = 0;
        got = 0;
        stall_cnt = 0;
        stalled_once = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && !stalled_once) begin
                stalled_once = 1;
                stall_cnt = 2;
            end
            out_ready = (stall_cnt == 0);
            in_valid  = (idx_in < 4);
            in_data   = (idx_in < 4) ? bp_in[idx_in] : 12'h000;
            #1;
            if (stall_cnt > 0) begin
                $display("stall: in_ready=%0d out_data=0x%04h", in_ready, out_data);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_hold_data", 32'(out_data), 32'h0100);
                stall_cnt--;
            end else if (out_valid) begin
                $display("bp out[%0d] = 0x%04h", got, out_data);
                check("bp_order", 32'(out_data), 32'(bp_exp[got]));
                got++;
            end
            if (in_valid && in_ready) idx_in++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_stalled", 32'(stalled_once), 32'd1);
        check("bp_count", 32'(got), 32'd4);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        $display("bp: extra outputs after stream = %0d", extra);
        check("bp_no_dup", 32'(extra), 32'd0);

        // Reset with two words in flight.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'h400;
        @(negedge clk);
        in_data  = 12'h440;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("post-reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("midrst_dropped", 32'(extra), 32'd0);
        run_vec(12'h3C0, 1'b0, 16'h0100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/float12_to_fixed.md
Name: float12_to_fixed

Overview:
- Pipelined converter from the 12-bit float format produced by the adder datapath into signed two's-complement fixed point.
- Float format: sign[11], exponent[10:6] with bias 15, mantissa[5:0] with a hidden leading 1.
- Sits at the back end of the float arithmetic chain and feeds fixed-point consumers such as the output buffer and debug readback.
- Valid/ready streaming on both sides, 3-cycle latency, optional negative clipping (ReLU), and saturation with a flag.

Parameters:
- OUT_W, 16: output width in bits; legal range 8..32.
- FRAC_W, 8: number of fractional bits in the output; legal range 0..OUT_W-2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  converter can accept a word this cycle.
- in_data_i  in  12  float12 operand.
- neg_clip_i  in  1  when 1, a negative result is forced to 0; sampled with in_data_i.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  downstream accepts the word.
- out_data_o  out  OUT_W  signed fixed-point result.
- sat_o  out  1  result was clamped; qualified by out_valid_o.

Behaviour:
- Reset: in one cycle with rst_i=1, all stage valids clear to 0. out_valid_o=0, out_data_o=0, sat_o=0.
- Reset mid-stream drops every in-flight word. in_ready_o is 1 the first cycle after reset.
- Advance enable: adv = ~out_valid_o | out_ready_i.
  - in_ready_o = adv, combinational.
  - All three stages shift together only when adv=1.
  - Bubbles are carried through, not collapsed.
  - When adv=0, every stage register holds, including data, sat_o and valid.
- Input transfer when in_valid_i & in_ready_o. Output transfer when out_valid_o & out_ready_i.
- Latency: 3 adv cycles from input transfer to out_valid_o.
- Throughput: 1 word/cycle while out_ready_i=1.
- Stage 1 registers:
  - sign, exponent e, and m7 = {1, mantissa}.
  - zero flag = (e==0); any word with e==0 is zero, regardless of sign or mantissa.
  - neg_clip_i.
- Stage 2: magnitude computation.
  - sh = e - 21 + FRAC_W, signed.
  - sh >= 0: mag = m7 << sh. Internal width 17+FRAC_W bits, so no loss at e=31.
  - 1 <= -sh <= 7: r = -sh; mag = (m7 + 2^(r-1)) >> r. This rounds half-up on the magnitude.
  - -sh >= 8: mag = 0.
  - zero flag forces mag = 0.
- Stage 3: sign and saturation, registered to the outputs.
  - Positive, or mag==0: if mag > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1 with sat_o=1; otherwise output mag.
  - Negative: if mag > 2^(OUT_W-1), output -2^(OUT_W-1) with sat_o=1; otherwise output -mag.
  - A negative input exactly equal to 2^(OUT_W-1) is not a saturation.
  - Negative zero outputs 0 with sat_o=0.
  - Negative clipping: neg_clip_i=1 and sign=1 output 0 with sat_o=0, even if the magnitude would saturate.
- Exponent 31 is treated as an ordinary finite exponent. The format has no Inf/NaN.
- Simultaneous output transfer and input transfer in the same cycle is legal. No word is lost or duplicated.

Decomposition:
- Shared package float12_pkg holds:
  - field widths and bit positions: SGN_BIT=11, EXP_MSB=10, EXP_LSB=6, MAN_W=6;
  - EXP_BIAS=15;
  - a packed float12 struct typedef.
- The adder family uses the same package.
- One sub-module is natural: f12_round_shift. It implements the stage-2 combinational bidirectional shift plus round-half-up. Parameters: FRAC_W and internal width.

Test Plan (OUT_W=16, FRAC_W=8, out_ready_i=1 unless stated):
- Exact values: 0x3C0 (1.0) -> 0x0100 after 3 cycles, sat_o=0. 0xC10 (-2.5) -> 0xFD80. 0x3E0 (1.5) -> 0x0180.
- Rounding and underflow: 0x180 (2^-9, i.e. 0.5 LSB) -> 0x0001. 0x140 -> 0x0000. 0x03F (e=0) -> 0x0000. 0x800 -> 0x0000.
- Saturation: 0x7FF -> 0x7FFF with sat_o=1. 0xFFF -> 0x8000 with sat_o=1. 0x580 (+128.0) -> 0x7FFF with sat_o=1. 0xD80 (-128.0) -> 0x8000 with sat_o=0.
- Negative clip: neg_clip_i=1 with 0xC10 -> 0x0000. neg_clip_i=1 with 0xFFF -> 0x0000, sat_o=0. neg_clip_i=1 with 0x3C0 -> 0x0100.
- Backpressure: stream 0x3C0, 0x400, 0x440, 0x480 back to back; drop out_ready_i for 2 cycles when the first word appears.
  - Required: out_data_o holds 0x0100, in_ready_o=0 during the stall.
  - Then 0x0100, 0x0200, 0x0400, 0x0800 arrive in order, with no loss or duplication.
- Reset mid-stream: assert rst_i for 1 cycle with 2 words in flight -> out_valid_o=0 the next cycle and neither word ever appears. A new word 0x3C0 then yields 0x0100 3 cycles later.
